// File: rtl/dm_responder.sv
// dm_responder: memory end of the CPU load/store interface.
//
// Accepts one load/store at a time on a valid/ready request channel, spends
// WAIT_CYCLES cycles in WAIT, executes the access against a local word array
// and returns the sized, extended result on a valid/ready response channel.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (IDLE only)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   req_ctrl    000 word, 001 half s, 010 half u, 011 byte s, 100 byte u
//   resp_valid  response present, held until resp_ready
//   resp_ready  requester takes the response
//   resp_rdata  load result; 0 for stores and errors
//   resp_err    misaligned, out-of-range or illegal-ctrl request
module dm_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned Depth     = 1 << ADDR_WIDTH;
    localparam bit          NoWait    = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CntInit   = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_ctrl;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [31:0] r_mem [Depth];

    // Request fields seen by the access logic. With no wait the access runs in
    // the acceptance cycle, so it must use the live request, not the latch.
    logic                  w_from_req;
    logic                  w_x_we;
    logic [31:0]           w_x_addr;
    logic [31:0]           w_x_wdata;
    logic [2:0]            w_x_ctrl;
    logic                  w_accept;
    logic                  w_exec;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [31:0]           w_rword;
    logic [7:0]            w_lane_byte;
    logic [15:0]           w_lane_half;
    logic [31:0]           w_load;
    logic [31:0]           w_rdata;
    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_bad_ctrl;
    logic                  w_err;
    logic [3:0]            w_be;
    logic [31:0]           w_wlanes;

    assign w_from_req = (r_state == StIdle);
    assign w_x_we     = w_from_req ? req_we    : r_we;
    assign w_x_addr   = w_from_req ? req_addr  : r_addr;
    assign w_x_wdata  = w_from_req ? req_wdata : r_wdata;
    assign w_x_ctrl   = w_from_req ? req_ctrl  : r_ctrl;

    assign w_accept = (r_state == StIdle) && req_valid;
    assign w_exec   = (NoWait && w_accept) || ((r_state == StWait) && (r_cnt == 4'd0));

    // ---------------------------------------------------------------------
    // Error checks
    // ---------------------------------------------------------------------
    assign w_out_of_range = (w_x_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_bad_ctrl     = (w_x_ctrl > 3'd4);

    always_comb begin
        w_misalign = 1'b0;
        case (w_x_ctrl)
            3'b000:         w_misalign = |w_x_addr[1:0];
            3'b001, 3'b010: w_misalign = w_x_addr[0];
            default:        w_misalign = 1'b0;
        endcase
    end

    assign w_err = w_misalign || w_out_of_range || w_bad_ctrl;

    // ---------------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------------
    assign w_index     = w_x_addr[ADDR_WIDTH+1:2];
    assign w_rword     = r_mem[w_index];
    assign w_lane_byte = w_rword[{w_x_addr[1:0], 3'b000} +: 8];
    assign w_lane_half = w_x_addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = 32'd0;
        case (w_x_ctrl)
            3'b000:  w_load = w_rword;
            3'b001:  w_load = {{16{w_lane_half[15]}}, w_lane_half};
            3'b010:  w_load = {16'd0, w_lane_half};
            3'b011:  w_load = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b100:  w_load = {24'd0, w_lane_byte};
            default: w_load = 32'd0;
        endcase
    end

    assign w_rdata = (w_x_we || w_err) ? 32'd0 : w_load;

    // ---------------------------------------------------------------------
    // Store path: replicate the store data across lanes, enable only the
    // addressed ones.
    // ---------------------------------------------------------------------
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_x_wdata;
        case (w_x_ctrl)
            3'b000: w_be = 4'b1111;
            3'b001, 3'b010: begin
                w_be     = w_x_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_x_wdata[15:0]}};
            end
            3'b011, 3'b100: begin
                w_be     = 4'b0001 << w_x_addr[1:0];
                w_wlanes = {4{w_x_wdata[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    assign w_write = w_exec && w_x_we && !w_err;

    // Array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs. The result is captured on the
    // execute edge; resp_valid follows one cycle later so that the response
    // appears WAIT_CYCLES+1 edges after acceptance for every WAIT_CYCLES.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_ctrl       <= 3'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_ctrl      <= req_ctrl;
                        r_req_ready <= 1'b0;
                        if (NoWait) begin
                            r_state      <= StResp;
                            r_resp_rdata <= w_rdata;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= CntInit;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= StResp;
                        r_resp_rdata <= w_rdata;
                        r_resp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: instance A (WAIT_CYCLES=2) is tracked every cycle
// against a byte-addressed memory model; instance B (WAIT_CYCLES=0) gets
// directed checks only.
module tb_dm_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned WC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_a = 1'b0, rstn_b = 1'b0;
    logic        req_valid_a = 1'b0, req_we_a = 1'b0, resp_ready_a = 1'b1;
    logic        req_valid_b = 1'b0, req_we_b = 1'b0, resp_ready_b = 1'b1;
    logic [31:0] req_addr_a = '0, req_wdata_a = '0, req_addr_b = '0, req_wdata_b = '0;
    logic [2:0]  req_ctrl_a = '0, req_ctrl_b = '0;
    logic        req_ready_a, resp_valid_a, resp_err_a;
    logic        req_ready_b, resp_valid_b, resp_err_b;
    logic [31:0] resp_rdata_a, resp_rdata_b;

    dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) u_dut_a (
        .clk        (clk),
        .rstn       (rstn_a),
        .req_valid  (req_valid_a),
        .req_ready  (req_ready_a),
        .req_we     (req_we_a),
        .req_addr   (req_addr_a),
        .req_wdata  (req_wdata_a),
        .req_ctrl   (req_ctrl_a),
        .resp_valid (resp_valid_a),
        .resp_ready (resp_ready_a),
        .resp_rdata (resp_rdata_a),
        .resp_err   (resp_err_a)
    );

    dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_b (
        .clk        (clk),
        .rstn       (rstn_b),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_we     (req_we_b),
        .req_addr   (req_addr_b),
        .req_wdata  (req_wdata_b),
        .req_ctrl   (req_ctrl_b),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_b),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model of instance A: a byte memory plus an edge countdown
    // from acceptance to response.
    // ---------------------------------------------------------------------
    logic [7:0]  mb [int];
    logic        m_ready = 1'b1, m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_rdata = '0;
    int          m_cnt = 0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    logic [2:0]  p_ctrl;

    function automatic int acc_size(input logic [2:0] c);
        case (c)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    task automatic model_exec();
        int          sz;
        logic [31:0] v;
        sz      = acc_size(p_ctrl);
        v       = '0;
        m_rdata = '0;
        if (sz == 0) m_err = 1'b1;
        else m_err = ((p_addr % sz) != 0) || ((p_addr / 4) >= (32'd1 << AW));
        if (!m_err) begin
            if (p_we) begin
                for (int i = 0; i < sz; i++) mb[int'(p_addr) + i] = p_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++)
                    v[8*i +: 8] = mb.exists(int'(p_addr) + i) ? mb[int'(p_addr) + i] : 8'h00;
                if (p_ctrl == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
                if (p_ctrl == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
                m_rdata = v;
            end
        end
    endtask

    always @(posedge clk or negedge rstn_a) begin
        if (!rstn_a) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_cnt   = 0;
            m_rdata = '0;
            m_err   = 1'b0;
        end else if (m_valid) begin
            if (resp_ready_a) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_ready) begin
            if (req_valid_a) begin
                p_we    = req_we_a;
                p_addr  = req_addr_a;
                p_wdata = req_wdata_a;
                p_ctrl  = req_ctrl_a;
                m_ready = 1'b0;
                m_cnt   = WC + 1;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                model_exec();
                m_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn_a) begin
            check("a_req_ready", req_ready_a, m_ready);
            check("a_resp_valid", resp_valid_a, m_valid);
            if (m_valid) begin
                check("a_resp_rdata", resp_rdata_a, m_rdata);
                check("a_resp_err", resp_err_a, m_err);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ---------------------------------------------------------------------
    task automatic drive(input bit b, input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c);
        if (b) begin
            req_valid_b = v; req_we_b = we; req_addr_b = a; req_wdata_b = d; req_ctrl_b = c;
        end else begin
            req_valid_a = v; req_we_a = we; req_addr_a = a; req_wdata_a = d; req_ctrl_a = c;
        end
    endtask

    task automatic do_req(input bit b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] ctrl,
                          output logic [31:0] rd, output logic e, output int lat);
        int t;
        int acc;
        drive(b, 1'b1, we, addr, wd, ctrl);
        t = 0;
        while (!(b ? req_ready_b : req_ready_a) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("accept_in_time", t < 50, 1);
        @(posedge clk); #1;
        acc = cyc;
        drive(b, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        t = 0;
        while (!(b ? resp_valid_b : resp_valid_a) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("resp_in_time", t < 50, 1);
        lat = cyc - acc + 1;
        rd  = b ? resp_rdata_b : resp_rdata_a;
        e   = b ? resp_err_b : resp_err_a;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] rd;
        logic        e;
        int          lat;

        @(posedge clk); @(posedge clk); #1;
        check("rst_a_req_ready", req_ready_a, 1);
        check("rst_a_resp_valid", resp_valid_a, 0);
        check("rst_a_rdata", resp_rdata_a, 0);
        check("rst_a_err", resp_err_a, 0);
        check("rst_b_req_ready", req_ready_b, 1);
        check("rst_b_resp_valid", resp_valid_b, 0);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(posedge clk); #1;

        // Word store/load with latency
        do_req(0, 1, 32'h10, 32'hDEADBEEF, 3'd0, rd, e, lat);
        check("sw_err", e, 0);
        check("sw_rdata", rd, 0);
        check("sw_latency", lat, 4);
        do_req(0, 0, 32'h10, 32'h0, 3'd0, rd, e, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_latency", lat, 4);

        // Byte lane and extension
        do_req(0, 1, 32'h10, 32'h0, 3'd0, rd, e, lat);
        do_req(0, 1, 32'h13, 32'h80, 3'd3, rd, e, lat);
        check("sb_err", e, 0);
        do_req(0, 0, 32'h13, 32'h0, 3'd3, rd, e, lat);
        check("lb_signed", rd, 32'hFFFFFF80);
        do_req(0, 0, 32'h13, 32'h0, 3'd4, rd, e, lat);
        check("lb_unsigned", rd, 32'h00000080);
        do_req(0, 0, 32'h10, 32'h0, 3'd0, rd, e, lat);
        check("lw_after_sb", rd, 32'h80000000);

        // Half lane, extension and misalignment
        do_req(0, 1, 32'h22, 32'h8001, 3'd1, rd, e, lat);
        do_req(0, 0, 32'h22, 32'h0, 3'd1, rd, e, lat);
        check("lh_signed", rd, 32'hFFFF8001);
        do_req(0, 0, 32'h22, 32'h0, 3'd2, rd, e, lat);
        check("lh_unsigned", rd, 32'h00008001);
        do_req(0, 0, 32'h21, 32'h0, 3'd1, rd, e, lat);
        check("lh_misalign_err", e, 1);
        check("lh_misalign_rdata", rd, 0);

        // Rejected stores leave the array alone (all alias word 0)
        do_req(0, 1, 32'h0, 32'hA5A5A5A5, 3'd0, rd, e, lat);
        do_req(0, 1, 32'h1002, 32'hFFFFFFFF, 3'd0, rd, e, lat);
        check("sw_misalign_err", e, 1);
        do_req(0, 1, 32'd4 << AW, 32'hFFFFFFFF, 3'd0, rd, e, lat);
        check("sw_range_err", e, 1);
        do_req(0, 1, 32'h0, 32'h12345678, 3'd5, rd, e, lat);
        check("ctrl_illegal_err", e, 1);
        check("ctrl_illegal_rdata", rd, 0);
        do_req(0, 0, 32'h0, 32'h0, 3'd0, rd, e, lat);
        check("readback_unchanged", rd, 32'hA5A5A5A5);

        // Back-pressure with an ignored request
        resp_ready_a = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        for (int t = 0; t < 50 && !resp_valid_a; t++) begin
            @(posedge clk); #1;
        end
        check("bp_valid", resp_valid_a, 1);
        drive(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 3'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", resp_valid_a, 1);
            check("bp_rdata_held", resp_rdata_a, 32'h80000000);
            check("bp_req_ready_low", req_ready_a, 0);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        resp_ready_a = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", req_ready_a, 1);
        check("bp_release_valid", resp_valid_a, 0);
        repeat (6) @(posedge clk);
        #1;
        do_req(0, 0, 32'h10, 32'h0, 3'd0, rd, e, lat);
        check("ignored_store_absent", rd, 32'h80000000);

        // Reset during WAIT drops the pending store
        do_req(0, 1, 32'h30, 32'h11111111, 3'd0, rd, e, lat);
        drive(0, 1'b1, 1'b1, 32'h30, 32'h22222222, 3'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        @(posedge clk); #1;
        rstn_a = 1'b0;
        #1;
        check("midrst_req_ready", req_ready_a, 1);
        check("midrst_resp_valid", resp_valid_a, 0);
        check("midrst_rdata", resp_rdata_a, 0);
        check("midrst_err", resp_err_a, 0);
        @(posedge clk); #1;
        rstn_a = 1'b1;
        @(posedge clk); #1;
        do_req(0, 0, 32'h30, 32'h0, 3'd0, rd, e, lat);
        check("midrst_readback", rd, 32'h11111111);

        // Zero-wait instance
        do_req(1, 1, 32'h30, 32'h11111111, 3'd0, rd, e, lat);
        check("b_sw_latency", lat, 2);
        check("b_sw_err", e, 0);
        do_req(1, 0, 32'h30, 32'h0, 3'd0, rd, e, lat);
        check("b_lw_rdata", rd, 32'h11111111);
        check("b_lw_latency", lat, 2);
        drive(1, 1'b1, 1'b1, 32'h30, 32'h33333333, 3'd0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        rstn_b = 1'b0;
        #1;
        check("b_rst_req_ready", req_ready_b, 1);
        check("b_rst_resp_valid", resp_valid_b, 0);
        check("b_rst_rdata", resp_rdata_b, 0);
        @(posedge clk); #1;
        rstn_b = 1'b1;
        @(posedge clk); #1;
        // The store executed on its acceptance edge, before the reset.
        do_req(1, 0, 32'h30, 32'h0, 3'd0, rd, e, lat);
        check("b_executed_store_kept", rd, 32'h33333333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
